// File: rtl/rv32i_enc_pkg.sv
// Shared types and RV32I field constants for the instruction encoder.
// The ENC_LI_EXPAND_EN macro adds the EMIT2 state used by the two-word li expansion.
package rv32i_enc_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_SLL  = 6'd2,  OP_SLT  = 6'd3,
    OP_SLTU = 6'd4,  OP_XOR  = 6'd5,  OP_SRL  = 6'd6,  OP_SRA  = 6'd7,
    OP_OR   = 6'd8,  OP_AND  = 6'd9,
    OP_ADDI = 6'd10, OP_SLTI = 6'd11, OP_SLTIU = 6'd12, OP_XORI = 6'd13,
    OP_ORI  = 6'd14, OP_ANDI = 6'd15, OP_SLLI = 6'd16, OP_SRLI = 6'd17,
    OP_SRAI = 6'd18,
    OP_LB   = 6'd19, OP_LH   = 6'd20, OP_LW   = 6'd21, OP_LBU  = 6'd22,
    OP_LHU  = 6'd23,
    OP_SB   = 6'd24, OP_SH   = 6'd25, OP_SW   = 6'd26,
    OP_BEQ  = 6'd27, OP_BNE  = 6'd28, OP_BLT  = 6'd29, OP_BGE  = 6'd30,
    OP_BLTU = 6'd31, OP_BGEU = 6'd32,
    OP_JAL  = 6'd33, OP_JALR = 6'd34, OP_LUI  = 6'd35, OP_AUIPC = 6'd36,
    OP_LI   = 6'd37
  } enc_op_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U
  } fmt_t;

`ifdef ENC_LI_EXPAND_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT = 2'd1, ST_EMIT2 = 2'd2} enc_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT = 2'd1} enc_state_t;
`endif

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv32i_imm_pack.sv
// Places an immediate into its I/S/B/J/U/shamt bit positions and flags
// whether the value is representable in that format.
module rv32i_imm_pack
  import rv32i_enc_pkg::*;
(
  input  fmt_t        i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_bits,
  output logic        o_ok
);

  logic w_s12, w_s13, w_s21;

  // Sign-extension checks: the bits above the field must all equal its sign bit.
  assign w_s12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_s13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_s21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    o_bits = '0;
    o_ok   = 1'b1;
    case (i_fmt)
      FMT_I: begin
        o_bits[31:20] = i_imm[11:0];
        o_ok          = w_s12;
      end
      FMT_SH: begin
        o_bits[24:20] = i_imm[4:0];
        o_ok          = ~(|i_imm[31:5]);
      end
      FMT_S: begin
        o_bits[31:25] = i_imm[11:5];
        o_bits[11:7]  = i_imm[4:0];
        o_ok          = w_s12;
      end
      FMT_B: begin
        o_bits[31]    = i_imm[12];
        o_bits[30:25] = i_imm[10:5];
        o_bits[11:8]  = i_imm[4:1];
        o_bits[7]     = i_imm[11];
        o_ok          = w_s13 & ~i_imm[0];
      end
      FMT_J: begin
        o_bits[31]    = i_imm[20];
        o_bits[30:21] = i_imm[10:1];
        o_bits[20]    = i_imm[11];
        o_bits[19:12] = i_imm[19:12];
        o_ok          = w_s21 & ~i_imm[0];
      end
      FMT_U: o_bits[31:12] = i_imm[31:12];
      default: o_bits = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streams symbolic RV32I requests as encoded words into instruction memory.
// Define ENC_LI_EXPAND_EN to accept li and expand it into addi or lui(+addi).
module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [5:0]        i_in_op,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [31:0]       i_in_imm,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [31:0]       o_out_data,
  output logic              o_err,
  output logic              o_full
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  enc_state_t        r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_err, r_full;

  enc_op_t     w_op;
  fmt_t        w_fmt;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic        w_use_rd, w_use_rs1, w_use_rs2, w_known;
  logic [31:0] w_pimm, w_imm_bits, w_word;
  logic        w_imm_ok, w_legal, w_acc, w_hs;

`ifdef ENC_LI_EXPAND_EN
  logic [31:0] r_word2, w_word2;
  logic        r_has2, w_two, w_fits12;

  assign w_fits12 = (&i_in_imm[31:11]) | ~(|i_in_imm[31:11]);
  assign w_word2  = {i_in_imm[11:0], i_in_rd, 3'b000, i_in_rd, OPC_IALU};
`endif

  assign w_op        = enc_op_t'(i_in_op);
  assign o_in_ready  = (r_state == ST_IDLE) && !r_full;
  assign w_acc       = i_in_valid && o_in_ready && !i_clr;
  assign o_out_valid = (r_state != ST_IDLE);
  assign w_hs        = o_out_valid && i_out_ready;
  assign o_out_addr  = r_addr;
  assign o_out_data  = r_data;
  assign o_err       = r_err;
  assign o_full      = r_full;

  always_comb begin
    w_fmt     = FMT_R;
    w_opc     = OPC_R;
    w_f3      = 3'b000;
    w_f7      = F7_BASE;
    w_use_rd  = 1'b1;
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b0;
    w_known   = 1'b1;
    w_pimm    = i_in_imm;
`ifdef ENC_LI_EXPAND_EN
    w_two     = 1'b0;
`endif
    case (w_op)
      OP_ADD:  w_use_rs2 = 1'b1;
      OP_SUB:  begin w_use_rs2 = 1'b1; w_f7 = F7_ALT; end
      OP_SLL:  begin w_use_rs2 = 1'b1; w_f3 = 3'b001; end
      OP_SLT:  begin w_use_rs2 = 1'b1; w_f3 = 3'b010; end
      OP_SLTU: begin w_use_rs2 = 1'b1; w_f3 = 3'b011; end
      OP_XOR:  begin w_use_rs2 = 1'b1; w_f3 = 3'b100; end
      OP_SRL:  begin w_use_rs2 = 1'b1; w_f3 = 3'b101; end
      OP_SRA:  begin w_use_rs2 = 1'b1; w_f3 = 3'b101; w_f7 = F7_ALT; end
      OP_OR:   begin w_use_rs2 = 1'b1; w_f3 = 3'b110; end
      OP_AND:  begin w_use_rs2 = 1'b1; w_f3 = 3'b111; end
      OP_ADDI:  begin w_fmt = FMT_I;  w_opc = OPC_IALU; end
      OP_SLTI:  begin w_fmt = FMT_I;  w_opc = OPC_IALU; w_f3 = 3'b010; end
      OP_SLTIU: begin w_fmt = FMT_I;  w_opc = OPC_IALU; w_f3 = 3'b011; end
      OP_XORI:  begin w_fmt = FMT_I;  w_opc = OPC_IALU; w_f3 = 3'b100; end
      OP_ORI:   begin w_fmt = FMT_I;  w_opc = OPC_IALU; w_f3 = 3'b110; end
      OP_ANDI:  begin w_fmt = FMT_I;  w_opc = OPC_IALU; w_f3 = 3'b111; end
      OP_SLLI:  begin w_fmt = FMT_SH; w_opc = OPC_IALU; w_f3 = 3'b001; end
      OP_SRLI:  begin w_fmt = FMT_SH; w_opc = OPC_IALU; w_f3 = 3'b101; end
      OP_SRAI:  begin w_fmt = FMT_SH; w_opc = OPC_IALU; w_f3 = 3'b101; w_f7 = F7_ALT; end
      OP_LB:  begin w_fmt = FMT_I; w_opc = OPC_LOAD; end
      OP_LH:  begin w_fmt = FMT_I; w_opc = OPC_LOAD; w_f3 = 3'b001; end
      OP_LW:  begin w_fmt = FMT_I; w_opc = OPC_LOAD; w_f3 = 3'b010; end
      OP_LBU: begin w_fmt = FMT_I; w_opc = OPC_LOAD; w_f3 = 3'b100; end
      OP_LHU: begin w_fmt = FMT_I; w_opc = OPC_LOAD; w_f3 = 3'b101; end
      OP_SB: begin w_fmt = FMT_S; w_opc = OPC_STORE; w_use_rd = 1'b0; w_use_rs2 = 1'b1; end
      OP_SH: begin w_fmt = FMT_S; w_opc = OPC_STORE; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b001; end
      OP_SW: begin w_fmt = FMT_S; w_opc = OPC_STORE; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b010; end
      OP_BEQ:  begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_use_rd = 1'b0; w_use_rs2 = 1'b1; end
      OP_BNE:  begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b001; end
      OP_BLT:  begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b100; end
      OP_BGE:  begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b101; end
      OP_BLTU: begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b110; end
      OP_BGEU: begin w_fmt = FMT_B; w_opc = OPC_BRANCH; w_use_rd = 1'b0; w_use_rs2 = 1'b1; w_f3 = 3'b111; end
      OP_JAL:   begin w_fmt = FMT_J; w_opc = OPC_JAL;   w_use_rs1 = 1'b0; end
      OP_JALR:  begin w_fmt = FMT_I; w_opc = OPC_JALR; end
      OP_LUI:   begin w_fmt = FMT_U; w_opc = OPC_LUI;   w_use_rs1 = 1'b0; end
      OP_AUIPC: begin w_fmt = FMT_U; w_opc = OPC_AUIPC; w_use_rs1 = 1'b0; end
`ifdef ENC_LI_EXPAND_EN
      OP_LI: begin
        w_use_rs1 = 1'b0;
        if (w_fits12) begin
          w_fmt = FMT_I;
          w_opc = OPC_IALU;
        end else begin
          // Bias by 0x800 so the sign-extended addi low part lands back on imm.
          w_fmt  = FMT_U;
          w_opc  = OPC_LUI;
          w_pimm = i_in_imm + 32'h0000_0800;
          w_two  = |i_in_imm[11:0];
        end
      end
`endif
      default: w_known = 1'b0;
    endcase
  end

  rv32i_imm_pack u_imm_pack (
    .i_fmt  (w_fmt),
    .i_imm  (w_pimm),
    .o_bits (w_imm_bits),
    .o_ok   (w_imm_ok)
  );

  assign w_legal = w_known && w_imm_ok;
  assign w_word  = w_imm_bits | {w_f7, (w_use_rs2 ? i_in_rs2 : 5'd0),
                                 (w_use_rs1 ? i_in_rs1 : 5'd0), w_f3,
                                 (w_use_rd ? i_in_rd : 5'd0), w_opc};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_acc && w_legal) w_next = ST_EMIT;
`ifdef ENC_LI_EXPAND_EN
      // A first li word that fills memory drops the second one.
      ST_EMIT:  if (w_hs) w_next = (r_has2 && r_addr != LAST) ? ST_EMIT2 : ST_IDLE;
      ST_EMIT2: if (w_hs) w_next = ST_IDLE;
`else
      ST_EMIT:  if (w_hs) w_next = ST_IDLE;
`endif
      default: w_next = ST_IDLE;
    endcase
    if (i_clr) w_next = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= BASE;
      r_data <= '0;
      r_err  <= 1'b0;
      r_full <= 1'b0;
`ifdef ENC_LI_EXPAND_EN
      r_word2 <= '0;
      r_has2  <= 1'b0;
`endif
    end else if (i_clr) begin
      r_addr <= BASE;
      r_err  <= 1'b0;
      r_full <= 1'b0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_acc && w_legal) begin
        r_data <= w_word;
`ifdef ENC_LI_EXPAND_EN
        r_word2 <= w_word2;
        r_has2  <= w_two;
`endif
      end
      if (w_hs) begin
        if (r_addr == LAST) r_full <= 1'b1;
        else                r_addr <= r_addr + 1'b1;
`ifdef ENC_LI_EXPAND_EN
        if (r_state == ST_EMIT && r_has2) r_data <= r_word2;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed vectors plus hand sequences for backpressure, reset, li and full/clr.
module tb_rv32i_instr_encoder;
  import rv32i_enc_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [5:0]  in_op = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        in_ready, out_valid, err, full;
  logic [9:0]  out_addr;
  logic [31:0] out_data;

  logic        s_clr = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic        s_in_ready, s_out_valid, s_err, s_full;
  logic [1:0]  s_out_addr;
  logic [31:0] s_out_data;

  int checks = 0, failures = 0;
  int exp_addr = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        bad;
    logic [31:0] data;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_op(in_op), .i_in_rd(rd), .i_in_rs1(rs1), .i_in_rs2(rs2), .i_in_imm(imm),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_addr(out_addr),
    .o_out_data(out_data), .o_err(err), .o_full(full)
  );

  rv32i_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_clr(s_clr), .i_in_valid(s_in_valid), .o_in_ready(s_in_ready),
    .i_in_op(in_op), .i_in_rd(rd), .i_in_rs1(rs1), .i_in_rs2(rs2), .i_in_imm(imm),
    .o_out_valid(s_out_valid), .i_out_ready(s_out_ready), .o_out_addr(s_out_addr),
    .o_out_data(s_out_data), .o_err(s_err), .o_full(s_full)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addv(input string nm, input logic [5:0] op, input int d, input int s1,
                      input int s2, input logic [31:0] im, input logic bad, input logic [31:0] dat);
    vec_t v;
    v.name = nm; v.op = op; v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.imm = im; v.bad = bad; v.data = dat;
    vq.push_back(v);
  endtask

  task automatic set_req(input logic [5:0] op, input int d, input int s1, input int s2,
                         input logic [31:0] im);
    in_op = op; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im;
  endtask

  // Drives one request on the main encoder; returns at the negedge after acceptance.
  task automatic send(input logic [5:0] op, input int d, input int s1, input int s2,
                      input logic [31:0] im);
    @(negedge clk);
    set_req(op, d, s1, s2, im);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    addv("add",      OP_ADD,  3, 1, 2, 32'd0,        1'b0, 32'h002081B3);
    addv("sub",      OP_SUB,  5, 6, 7, 32'd0,        1'b0, 32'h407302B3);
    addv("beq-4",    OP_BEQ,  9, 1, 2, -32'sd4,      1'b0, 32'hFE208EE3);
    addv("beq-3",    OP_BEQ,  0, 1, 2, -32'sd3,      1'b1, 32'h0);
    addv("addi2048", OP_ADDI, 1, 0, 0, 32'd2048,     1'b1, 32'h0);
    addv("slli32",   OP_SLLI, 1, 2, 0, 32'd32,       1'b1, 32'h0);
    addv("addi-1",   OP_ADDI, 1, 2, 7, -32'sd1,      1'b0, 32'hFFF10093);
    addv("lw",       OP_LW,   5, 2, 0, 32'd8,        1'b0, 32'h00812283);
    addv("sw",       OP_SW,   9, 2, 5, 32'd12,       1'b0, 32'h00512623);
    addv("srai",     OP_SRAI, 1, 2, 0, 32'd3,        1'b0, 32'h40315093);
    addv("jal",      OP_JAL,  1, 7, 7, 32'd2048,     1'b0, 32'h001000EF);
    addv("jal2^20",  OP_JAL,  1, 0, 0, 32'h0010_0000, 1'b1, 32'h0);
    addv("lui",      OP_LUI,  5, 3, 4, 32'h12345ABC, 1'b0, 32'h123452B7);
    addv("bltumax",  OP_BLTU, 0, 3, 4, 32'd4094,     1'b0, 32'h7E41EFE3);
    addv("unknown",  6'd63,   1, 1, 1, 32'd0,        1'b1, 32'h0);
    addv("jalr",     OP_JALR, 0, 1, 0, 32'd0,        1'b0, 32'h00008067);
    addv("auipc",    OP_AUIPC,2, 0, 0, 32'h00001000, 1'b0, 32'h00001117);

    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_addr", 32'(out_addr), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      chk({vq[i].name, " ready"}, 32'(in_ready), 32'd1);
      send(vq[i].op, vq[i].rd, vq[i].rs1, vq[i].rs2, vq[i].imm);
      chk({vq[i].name, " err"}, 32'(err), 32'(vq[i].bad));
      chk({vq[i].name, " valid"}, 32'(out_valid), 32'(!vq[i].bad));
      chk({vq[i].name, " addr"}, 32'(out_addr), 32'(exp_addr));
      if (!vq[i].bad) begin
        chk({vq[i].name, " data"}, out_data, vq[i].data);
        exp_addr++;
      end
      @(negedge clk);
      chk({vq[i].name, " idle"}, 32'(out_valid), 32'd0);
      chk({vq[i].name, " err pulse"}, 32'(err), 32'd0);
      chk({vq[i].name, " addr after"}, 32'(out_addr), 32'(exp_addr));
    end

`ifdef ENC_LI_EXPAND_EN
    send(OP_LI, 10, 9, 9, 32'h12345FFF);
    chk("li lui data", out_data, 32'h12346537);
    chk("li lui addr", 32'(out_addr), 32'(exp_addr));
    @(negedge clk);
    chk("li addi valid", 32'(out_valid), 32'd1);
    chk("li addi data", out_data, 32'hFFF50513);
    chk("li addi addr", 32'(out_addr), 32'(exp_addr + 1));
    @(negedge clk);
    chk("li done", 32'(out_valid), 32'd0);
    exp_addr += 2;
    send(OP_LI, 7, 3, 3, 32'd5);
    chk("li small data", out_data, 32'h00500393);
    @(negedge clk);
    chk("li small done", 32'(out_valid), 32'd0);
    exp_addr++;
    send(OP_LI, 1, 0, 0, 32'h12345000);
    chk("li luionly data", out_data, 32'h123450B7);
    @(negedge clk);
    chk("li luionly done", 32'(out_valid), 32'd0);
    exp_addr++;
`else
    send(OP_LI, 10, 0, 0, 32'h12345FFF);
    chk("li off err", 32'(err), 32'd1);
    chk("li off valid", 32'(out_valid), 32'd0);
    @(negedge clk);
`endif
    chk("addr after li", 32'(out_addr), 32'(exp_addr));

    // Backpressure: word and address hold while the memory stalls.
    out_ready = 1'b0;
    send(OP_ADD, 3, 1, 2, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("stall valid", 32'(out_valid), 32'd1);
      chk("stall data", out_data, 32'h002081B3);
      chk("stall addr", 32'(out_addr), 32'(exp_addr));
      chk("stall ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_addr++;
    chk("stall released", 32'(out_valid), 32'd0);
    chk("stall addr inc", 32'(out_addr), 32'(exp_addr));

    // Asynchronous reset while a word is pending.
    out_ready = 1'b0;
    send(OP_SUB, 5, 6, 7, 32'd0);
    chk("pre-rst valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst mid valid", 32'(out_valid), 32'd0);
    chk("rst mid addr", 32'(out_addr), 32'd0);
    chk("rst mid data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(OP_ADD, 3, 1, 2, 32'd0);
    chk("post-rst addr", 32'(out_addr), 32'd0);
    chk("post-rst data", out_data, 32'h002081B3);
    @(negedge clk);

    // Small memory: fill all four words, then restart with clr.
    set_req(OP_ADD, 3, 1, 2, 32'd0);
    for (int k = 0; k < 4; k++) begin
      s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      chk("small addr", 32'(s_out_addr), 32'(k));
      chk("small valid", 32'(s_out_valid), 32'd1);
      @(negedge clk);
    end
    chk("small full", 32'(s_full), 32'd1);
    chk("small ready", 32'(s_in_ready), 32'd0);
    chk("small addr held", 32'(s_out_addr), 32'd3);
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("small full blocks", 32'(s_out_valid), 32'd0);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    chk("clr full", 32'(s_full), 32'd0);
    chk("clr ready", 32'(s_in_ready), 32'd1);
    chk("clr addr", 32'(s_out_addr), 32'd0);
    set_req(OP_SUB, 5, 6, 7, 32'd0);
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("clr next addr", 32'(s_out_addr), 32'd0);
    chk("clr next data", s_out_data, 32'h407302B3);
    @(negedge clk);
    chk("clr next inc", 32'(s_out_addr), 32'd1);

    // clr coincident with an output handshake drops the word.
    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("clr-hs pending", 32'(s_out_valid), 32'd1);
    s_clr = 1'b1;
    s_out_ready = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    chk("clr-hs dropped", 32'(s_out_valid), 32'd0);
    chk("clr-hs addr", 32'(s_out_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
# rv32i_instr_encoder

Sequential RV32I instruction encoder: the inverse of the control-unit decoder. It accepts symbolic instruction requests (operation, register indices, immediate), packs them into 32-bit machine words using the same opcode/funct3/funct7 assignments the datapath decodes, and streams them with consecutive word addresses into instruction memory. It sits between the test/boot loader and the instruction-memory write port of the single-cycle processor.

## Interface
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after reset or `clr`
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous restart: address to BASE_ADDR, `full` cleared, pending output dropped
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  6  operation code (`enc_op_t`)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, two's complement
- out_valid  out  1  word valid toward memory
- out_ready  in  1  memory accepts word
- out_addr  out  ADDR_W  word address
- out_data  out  32  encoded instruction
- err  out  1  one-cycle pulse: request rejected
- full  out  1  sticky: last address written

## Operation
- Ops: R (add sub sll slt sltu xor srl sra or and), I-ALU (addi slti sltiu xori ori andi slli srli srai), loads (lb lh lw lbu lhu), stores (sb sh sw), branches (beq bne blt bge bltu bgeu), jal, jalr, lui, auipc, li.
- Opcodes: R 0110011, I-ALU 0010011, load 0000011, jalr 1100111, branch 1100011, store 0100011, jal 1101111, lui 0110111, auipc 0010111.
- funct7 = 0100000 for sub/sra/srai, else 0. Branch funct3: 000,001,100,101,110,111. Load funct3: 000,001,010,100,101. Store: 000,001,010.
- Range checks (failure → `err`, nothing emitted, request consumed): I/S imm in [-2048,2047]; shift imm in [0,31]; B imm even, in [-4096,4094]; J imm even, in [-2^20, 2^20-2]. lui/auipc use in_imm[31:12], low bits ignored. Unknown in_op → `err`.
- Unused fields (e.g. rs2 for I-type) are encoded as 0.
- FSM: IDLE → EMIT on accepted legal request; EMIT → IDLE (or EMIT2 for two-word li) on out handshake; EMIT2 → IDLE on handshake. Illegal request: IDLE → IDLE with `err`.
- `in_ready` = (state == IDLE) && !full.
- out_addr increments by 1 on each out handshake; handshake at address 2^ADDR_W-1 sets `full`, address holds. `clr` clears it.
- `clr` coincident with any handshake: `clr` wins, word dropped, address = BASE_ADDR.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_addr BASE_ADDR, err 0, full 0; in_ready 1.
- Request accepted cycle N → out_valid, out_data registered, visible cycle N+1. `err` pulses in N+1 for rejects.
- out_data/out_addr stable while out_valid && !out_ready.
- Reset mid-operation aborts any word, including second li word.

## Configuration
- `ENC_LI_EXPAND_EN` defined: `li rd,imm` expands. If imm fits 12-bit signed → single `addi rd,x0,imm`. Else `lui rd,(imm+0x800)>>12`, then `addi rd,rd,imm[11:0]` unless imm[11:0]==0 (lui only).
- Undefined: `li` is an unknown op → `err`; FSM has no EMIT2 state.

## Structure
- Package `rv32i_enc_pkg`: `enc_op_t` enum, opcode/funct3/funct7 localparams, state enum.
- Sub-module `rv32i_imm_pack`: combinational I/S/B/J/U field placement plus range-check flag; top holds FSM, address counter, output registers.

## Test plan
- add x3,x1,x2 after reset → out_data 0x002081B3, out_addr 0; sub x5,x6,x7 → 0x407302B3 at addr 1.
- beq x1,x2,-4 → 0xFE208EE3; beq imm -3 → err pulse, no out_valid, address unchanged.
- li x10,0x12345FFF (macro on) → 0x12346537 then 0xFFF50513 at consecutive addresses; macro off → err.
- addi imm 2048 → err; slli imm 32 → err; in_ready returns 1 next cycle.
- out_ready low 3 cycles → out_data/out_addr held; rst asserted in EMIT → out_valid 0 immediately, addr BASE_ADDR.
- ADDR_W=2: four words → full=1, in_ready=0; clr → full=0, next word at addr 0.
